// File: rtl/perf_tx_pkg.sv
// perf_tx_pkg: shared states, framing constants and checksum helper for the counter UART.
package perf_tx_pkg;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP} state_t;
  localparam logic [7:0] HEADER = 8'hA5;
  localparam int FRAME_BYTES = 14;
  function automatic logic [7:0] frame_checksum(input logic [95:0] snap);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 12; i++) c ^= snap[8*i +: 8];
    return c;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer with baud timing; accepts the next byte on the last stop-bit cycle.
module uart_tx_byte
  import perf_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic tick, load;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign byte_ready = state == IDLE || (state == STOP && tick);
  assign load = byte_valid && byte_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = load ? START_BIT : IDLE;
      START_BIT: state_n = tick ? DATA : START_BIT;
      DATA:      state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
      STOP:      state_n = load ? START_BIT : (tick ? IDLE : STOP);
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (load) begin
        sh      <= byte_data;
        tx      <= 1'b0;
        bit_cnt <= '0;
      end else if (tick) begin
        if (state == START_BIT) begin
          tx <= sh[0];
          sh <= sh >> 1;
        end else if (state == DATA) begin
          tx      <= (bit_cnt == 3'd7) ? 1'b1 : sh[0];
          sh      <= sh >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end else if (state == STOP) begin
          tx <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/perf_counter_uart_tx.sv
// perf_counter_uart_tx: snapshots three perf counters and streams them as a 14-byte framed UART burst.
module perf_counter_uart_tx
  import perf_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] stall_cnt,
  input  logic [31:0] arith_cnt,
  input  logic [31:0] mem_cnt,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);
  logic [95:0] snap, snap_sh;
  logic [3:0] idx, nidx;
  logic [6:0] boff;
  logic [7:0] byte_data;
  logic byte_valid, byte_ready, take;
  // The done cycle still counts as part of the frame, so a start there is dropped.
  assign take = start && !busy && !done;
  assign nidx = idx + 4'd1;
  assign boff = {nidx - 4'd1, 3'b000};
  assign snap_sh = snap >> boff;
  assign byte_valid = busy ? idx != LAST_IDX : take;
  assign byte_data = !busy ? HEADER : (nidx == LAST_IDX ? frame_checksum(snap) : snap_sh[7:0]);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      idx  <= '0;
      snap <= '0;
    end else begin
      done <= 1'b0;
      if (take) begin
        busy <= 1'b1;
        idx  <= '0;
        snap <= {mem_cnt, arith_cnt, stall_cnt};
      end else if (busy && byte_ready) begin
        if (idx == LAST_IDX) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= nidx;
        end
      end
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_perf_counter_uart_tx.sv
// tb_perf_counter_uart_tx: directed frame vectors plus hand-built corner sequences at CLKS_PER_BIT=4.
module tb_perf_counter_uart_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] stall_cnt = '0, arith_cnt = '0, mem_cnt = '0;
  logic tx, busy, done;
  int checks = 0, failures = 0, busy_cnt = 0, done_cnt = 0;
  typedef struct {
    logic [31:0] s, a, m;
    logic [111:0] exp;
  } vec_t;
  vec_t vecs[3];
  localparam logic [111:0] BASIC = 112'hA5_03000000_78563412_FF000000_F4;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end
  perf_counter_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stall_cnt(stall_cnt), .arith_cnt(arith_cnt),
    .mem_cnt(mem_cnt), .tx(tx), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic recv_byte(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    ok = 1'b1;
    b = '0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      ok = 1'b0;
      return;
    end
    repeat (2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask
  task automatic recv_frame(input string name, input logic [111:0] exp);
    logic [7:0] b;
    logic ok;
    for (int k = 0; k < 14; k++) begin
      recv_byte(b, ok);
      chk($sformatf("%s byte%0d", name, k), {23'd0, ok, b}, {23'd0, 1'b1, exp[111-8*k -: 8]});
    end
  endtask
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done seen"}, 32'(n < 2000), 32'd1);
  endtask
  initial begin
    int b0, d0;
    logic [7:0] hdr;
    logic exp_bit;
    vecs[0] = '{32'h00000003, 32'h12345678, 32'h000000FF, BASIC};
    vecs[1] = '{32'h0, 32'h0, 32'h0, 112'hA5_000000000000000000000000_00};
    vecs[2] = '{32'h01020304, 32'h00000000, 32'h80000001, 112'hA5_04030201_00000000_01000080_85};
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      stall_cnt = vecs[v].s;
      arith_cnt = vecs[v].a;
      mem_cnt = vecs[v].m;
      @(negedge clk);
      b0 = busy_cnt;
      d0 = done_cnt;
      pulse_start();
      recv_frame($sformatf("vec%0d", v), vecs[v].exp);
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d busy cycles", v), 32'(busy_cnt - b0), 32'd560);
      chk($sformatf("vec%0d done pulses", v), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("vec%0d idle tx", v), 32'(tx), 32'd1);
    end
    hdr = 8'hA5;
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      exp_bit = (c < 4) ? 1'b0 : (c >= 36) ? 1'b1 : hdr[(c - 4) / 4];
      chk($sformatf("header bit cycle%0d", c), 32'(tx), 32'(exp_bit));
      @(negedge clk);
    end
    wait_done("timing");
    repeat (3) @(negedge clk);
    stall_cnt = 32'h00000003;
    arith_cnt = 32'h12345678;
    mem_cnt = 32'h000000FF;
    pulse_start();
    arith_cnt = 32'hDEADBEEF;
    recv_frame("snapshot", BASIC);
    wait_done("snapshot");
    repeat (3) @(negedge clk);
    arith_cnt = 32'h12345678;
    d0 = done_cnt;
    pulse_start();
    fork
      recv_frame("busy frame", BASIC);
      begin
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done("busy frame");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done-cycle start ignored busy", 32'(busy), 32'd0);
    chk("done-cycle start ignored tx", 32'(tx), 32'd1);
    pulse_start();
    recv_frame("second frame", BASIC);
    wait_done("second frame");
    @(negedge clk);
    chk("two done pulses", 32'(done_cnt - d0), 32'd2);
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset tx", 32'(tx), 32'd1);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (600) @(negedge clk);
    chk("no done after reset", 32'(done_cnt - d0), 32'd0);
    chk("idle tx after reset", 32'(tx), 32'd1);
    pulse_start();
    recv_frame("after reset", BASIC);
    wait_done("after reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
